fetch_stage: RTL and testbench

- Instruction-fetch stage of the MIPS pipeline, directly upstream of the opcode decoder.
- Owns the PC and issues one instruction-memory request at a time over a req/gnt/rvalid handshake.
- Delivers fetched words into an IF/ID register whose op field drives the decoder's op5..op0 inputs.
- Handles downstream stall and branch/jump redirect (flush), with a 1-entry skid buffer so a response that arrives during a stall is never lost.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 43 ++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// reset/flush defaults and the sequential PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched word {instr, pc4} that arrives
// while the decode stage is stalled. Clear wins over load, load over unload.
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  // Capture a word on load, drop it on unload or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD_DEF;
      r_pc4   <= 32'd0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs a single-outstanding
// req/gnt/rvalid handshake to instruction memory and fills the IF/ID register.
// A word returning during a decode stall is parked in a one-entry skid buffer.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [5:0]  ifid_op
);

  fetch_state_e r_state;
  fetch_state_e w_nextState;

  logic [31:0] r_pc;
  logic [31:0] r_inflightAddr;
  logic        r_ifidValid;
  logic [31:0] r_ifidInstr;
  logic [31:0] r_ifidPc4;

  logic        w_grant;
  logic        w_respWait;
  logic        w_deliver;
  logic        w_toIfid;
  logic        w_skidLoad;
  logic        w_skidUnload;
  logic        w_skidValid;
  logic [31:0] w_skidInstr;
  logic [31:0] w_skidPc4;
  logic [31:0] w_respPc4;

  // No request while held in reset or while the skid still holds a word.
  assign imem_req     = rst_n & (r_state == S_REQ) & ~w_skidValid;
  assign imem_addr    = r_pc;
  assign w_grant      = imem_req & imem_gnt;
  assign w_respWait   = (r_state == S_WAIT) & imem_rvalid;
  assign w_deliver    = w_respWait & ~redirect;
  assign w_toIfid     = w_deliver & (~r_ifidValid | ~stall);
  assign w_skidLoad   = w_deliver & r_ifidValid & stall;
  assign w_skidUnload = ~redirect & ~stall & w_skidValid;
  assign w_respPc4    = r_inflightAddr + PC_STEP;

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skidLoad),
    .i_unload (w_skidUnload),
    .i_clear  (redirect),
    .i_instr  (imem_rdata),
    .i_pc4    (w_respPc4),
    .o_valid  (w_skidValid),
    .o_instr  (w_skidInstr),
    .o_pc4    (w_skidPc4)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_REQ;
    else        r_state <= w_nextState;
  end

  // Next state: a redirect turns any in-flight request into one to discard.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_REQ:   if (w_grant) w_nextState = redirect ? S_DROP : S_WAIT;
      S_WAIT:  begin
        if (imem_rvalid)   w_nextState = S_REQ;
        else if (redirect) w_nextState = S_DROP;
      end
      S_DROP:  if (imem_rvalid) w_nextState = S_REQ;
      default: w_nextState = S_REQ;
    endcase
  end

  // PC and the address of the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc           <= RESET_PC;
      r_inflightAddr <= 32'd0;
    end else begin
      if (w_grant) r_inflightAddr <= r_pc;
      if (redirect)     r_pc <= redirect_pc;
      else if (w_grant) r_pc <= r_pc + PC_STEP;
    end
  end

  // IF/ID register: flush, fresh word, skid word, or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifidValid <= 1'b0;
      r_ifidInstr <= NOP_WORD;
      r_ifidPc4   <= 32'd0;
    end else if (redirect) begin
      r_ifidValid <= 1'b0;
      r_ifidInstr <= NOP_WORD;
    end else if (w_toIfid) begin
      r_ifidValid <= 1'b1;
      r_ifidInstr <= imem_rdata;
      r_ifidPc4   <= w_respPc4;
    end else if (!stall) begin
      if (w_skidValid) begin
        r_ifidValid <= 1'b1;
        r_ifidInstr <= w_skidInstr;
        r_ifidPc4   <= w_skidPc4;
      end else begin
        r_ifidValid <= 1'b0;
      end
    end
  end

  assign ifid_valid = r_ifidValid;
  assign ifid_instr = r_ifidInstr;
  assign ifid_pc4   = r_ifidPc4;
  assign ifid_op    = r_ifidInstr[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small memory driver plus a scoreboard of
// expected IF/ID contents pushed when a deliverable word is returned.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_op;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sbQueue[$];
  int   testsRun    = 0;
  int   testsFailed = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_op     (ifid_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one granted request at the expected address.
  task automatic doGrant(input string tag, input logic [31:0] addr);
    check({tag, ".addr"}, imem_addr, addr);
    check({tag, ".req"}, {31'd0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check({tag, ".reqWait"}, {31'd0, imem_req}, 32'd0);
  endtask

  // Return one word; deliverable words go onto the scoreboard.
  task automatic doResponse(input logic [31:0] word, input logic [31:0] addr, input bit deliver);
    exp_t e;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    if (deliver) begin
      e.instr = word;
      e.pc4   = addr + 32'd4;
      sbQueue.push_back(e);
    end
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] word);
    doGrant(tag, addr);
    doResponse(word, addr, 1'b1);
  endtask

  // Pop the oldest expected word and compare it with IF/ID.
  task automatic checkOutput(input string tag);
    exp_t e;
    if (sbQueue.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL %s.sb: observed empty scoreboard expected an entry", tag);
    end else begin
      e = sbQueue.pop_front();
      check({tag, ".valid"}, {31'd0, ifid_valid}, 32'd1);
      check({tag, ".instr"}, ifid_instr, e.instr);
      check({tag, ".pc4"}, ifid_pc4, e.pc4);
      check({tag, ".op"}, {26'd0, ifid_op}, {26'd0, e.instr[31:26]});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    tick();
    tick();

    check("rst.req", {31'd0, imem_req}, 32'd0);
    check("rst.valid", {31'd0, ifid_valid}, 32'd0);
    check("rst.instr", ifid_instr, 32'h0000_0000);
    check("rst.pc4", ifid_pc4, 32'd0);
    check("rst.addr", imem_addr, 32'h0000_3000);
    rst_n = 1'b1;
    #1;
    check("rel.req", {31'd0, imem_req}, 32'd1);

    // First fetch, response one cycle after the grant.
    applyStimulus("t1", 32'h0000_3000, 32'h8C01_0004);
    checkOutput("t1");
    check("t1.opLit", {26'd0, ifid_op}, {26'd0, 6'b100011});

    // Back-to-back fetches, a bubble between deliveries.
    doGrant("t2a", 32'h0000_3004);
    check("t2a.bubble", {31'd0, ifid_valid}, 32'd0);
    doResponse(32'h2401_0001, 32'h0000_3004, 1'b1);
    checkOutput("t2a");
    applyStimulus("t2b", 32'h0000_3008, 32'h2402_0002);
    checkOutput("t2b");

    // Stall with IF/ID full: the response parks in the skid.
    stall = 1'b1;
    doGrant("t3", 32'h0000_300C);
    check("t3.hold", ifid_pc4, 32'h0000_300C);
    doResponse(32'h0800_0C00, 32'h0000_300C, 1'b1);
    check("t3.skidReq", {31'd0, imem_req}, 32'd0);
    check("t3.holdInstr", ifid_instr, 32'h2402_0002);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    check("t3.stillHeld", ifid_pc4, 32'h0000_300C);
    stall = 1'b0;
    tick();
    checkOutput("t3");
    check("t3.nextReq", {31'd0, imem_req}, 32'd1);
    check("t3.nextAddr", imem_addr, 32'h0000_3010);

    // Redirect while waiting: flush and drop the late word.
    stall = 1'b1;
    doGrant("t4", 32'h0000_3010);
    check("t4.preValid", {31'd0, ifid_valid}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3040;
    tick();
    redirect = 1'b0;
    check("t4.flushValid", {31'd0, ifid_valid}, 32'd0);
    check("t4.flushInstr", ifid_instr, 32'h0000_0000);
    check("t4.dropReq", {31'd0, imem_req}, 32'd0);
    doResponse(32'hDEAD_BEEF, 32'h0000_3010, 1'b0);
    check("t4.dropValid", {31'd0, ifid_valid}, 32'd0);
    check("t4.newAddr", imem_addr, 32'h0000_3040);
    check("t4.newReq", {31'd0, imem_req}, 32'd1);

    // Redirect and rvalid together under stall.
    stall = 1'b0;
    applyStimulus("t5", 32'h0000_3040, 32'h2002_000A);
    checkOutput("t5");
    stall = 1'b1;
    doGrant("t5b", 32'h0000_3044);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3080;
    tick();
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    check("t5b.valid", {31'd0, ifid_valid}, 32'd0);
    check("t5b.instr", ifid_instr, 32'h0000_0000);
    check("t5b.req", {31'd0, imem_req}, 32'd1);
    check("t5b.addr", imem_addr, 32'h0000_3080);

    // Asynchronous reset while a request is outstanding.
    stall = 1'b0;
    applyStimulus("t6", 32'h0000_3080, 32'hAC22_0008);
    checkOutput("t6");
    stall = 1'b1;
    doGrant("t6b", 32'h0000_3084);
    rst_n = 1'b0;
    #2;
    check("t6.rstValid", {31'd0, ifid_valid}, 32'd0);
    check("t6.rstInstr", ifid_instr, 32'h0000_0000);
    check("t6.rstPc4", ifid_pc4, 32'd0);
    check("t6.rstReq", {31'd0, imem_req}, 32'd0);
    check("t6.rstAddr", imem_addr, 32'h0000_3000);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    tick();
    imem_rvalid = 1'b0;
    check("t6.staleValid", {31'd0, ifid_valid}, 32'd0);
    applyStimulus("t6c", 32'h0000_3000, 32'h8C01_0004);
    checkOutput("t6c");

    // Redirect to an unaligned address near the top; PC wraps.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    applyStimulus("t7", 32'hFFFF_FFFE, 32'h3C01_ABCD);
    checkOutput("t7");
    check("t7.wrapAddr", imem_addr, 32'h0000_0002);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
